// File: rtl/hamming_enc_engine.sv
// hamming_enc_engine: sequential SEC-DED Hamming(16,11) encoder walking NUM_MSG messages in byte-wide data memory.
// Optional high-byte format check is compiled in when HAM_ENC_CHECK_EN is defined.
module hamming_enc_engine #(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int ADDR_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd_en,
    input  logic [7:0]        i_mem_rd_data,
    output logic              o_mem_wr_en,
    output logic [7:0]        o_mem_wr_data,
    output logic              o_fmt_err
);
    typedef enum logic [2:0] {S_IDLE, S_RD_LO, S_RD_HI, S_CAP_HI, S_WR_LO, S_WR_HI, S_DONE} state_t;
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_idx, w_off, w_src, w_dst;
    logic [11:1]       r_d;
    logic [15:0]       w_cw;
    logic              w_accept, w_last, w_p8, w_p4, w_p2, w_p1, w_p0;
    assign w_accept = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = r_idx == ADDR_W'(NUM_MSG - 1);
    assign w_off    = r_idx << 1;
    assign w_src    = ADDR_W'(SRC_BASE) + w_off;
    assign w_dst    = ADDR_W'(DST_BASE) + w_off;
    assign w_p8     = ^r_d[11:5];
    assign w_p4     = ^r_d[11:8] ^ ^r_d[4:2];
    assign w_p2     = r_d[11] ^ r_d[10] ^ r_d[7] ^ r_d[6] ^ r_d[4] ^ r_d[3] ^ r_d[1];
    assign w_p1     = r_d[11] ^ r_d[9] ^ r_d[7] ^ r_d[5] ^ r_d[4] ^ r_d[2] ^ r_d[1];
    assign w_p0     = ^r_d ^ w_p8 ^ w_p4 ^ w_p2 ^ w_p1;
    assign w_cw     = {r_d[11:5], w_p8, r_d[4:2], w_p4, r_d[1], w_p2, w_p1, w_p0};
    // state, message index and captured message bits
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_d     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept)
                r_idx <= '0;
            else if (r_state == S_WR_HI)
                r_idx <= r_idx + ADDR_W'(1);
            if (r_state == S_RD_HI)
                r_d[8:1] <= i_mem_rd_data;
            if (r_state == S_CAP_HI)
                r_d[11:9] <= i_mem_rd_data[2:0];
        end
    end
    // next-state sequencing: five states per message
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_next = w_accept ? S_RD_LO : r_state;
            S_RD_LO:        w_next = S_RD_HI;
            S_RD_HI:        w_next = S_CAP_HI;
            S_CAP_HI:       w_next = S_WR_LO;
            S_WR_LO:        w_next = S_WR_HI;
            S_WR_HI:        w_next = w_last ? S_DONE : S_RD_LO;
            default:        w_next = S_IDLE;
        endcase
    end
    // memory port and status outputs decoded from the current state
    always_comb begin
        o_busy        = !(r_state == S_IDLE || r_state == S_DONE);
        o_done        = r_state == S_DONE;
        o_mem_rd_en   = r_state == S_RD_LO || r_state == S_RD_HI;
        o_mem_wr_en   = r_state == S_WR_LO || r_state == S_WR_HI;
        o_mem_addr    = r_state == S_RD_LO ? w_src :
                        r_state == S_RD_HI ? w_src + ADDR_W'(1) :
                        r_state == S_WR_LO ? w_dst :
                        r_state == S_WR_HI ? w_dst + ADDR_W'(1) : '0;
        o_mem_wr_data = r_state == S_WR_LO ? w_cw[7:0] :
                        r_state == S_WR_HI ? w_cw[15:8] : 8'h00;
    end
`ifdef HAM_ENC_CHECK_EN
    logic r_fmt_err;
    // sticky flag for nonzero padding bits in a message high byte
    always_ff @(posedge i_clk) begin
        if (!i_reset || w_accept)
            r_fmt_err <= 1'b0;
        else if (r_state == S_CAP_HI && |i_mem_rd_data[7:3])
            r_fmt_err <= 1'b1;
    end
    assign o_fmt_err = r_fmt_err;
`else
    logic w_unused_hi;
    assign w_unused_hi = |i_mem_rd_data[7:3];
    assign o_fmt_err   = 1'b0;
`endif
endmodule

// File: tb/tb_hamming_enc_engine.sv
// tb_hamming_enc_engine: randomized check of hamming_enc_engine against a positional Hamming model.
module tb_hamming_enc_engine;
    localparam int NUM_MSG = 15;
    localparam int DST     = 30;
    logic       clk = 1'b0;
    logic       reset, start, busy, done, rd_en, wr_en, fmt_err;
    logic [7:0] addr, rd_data, wr_data;
    logic [7:0] src_mem [0:255];
    logic [7:0] dst_mem [0:255];
    logic [10:0] msg [NUM_MSG];
    int n_cmp = 0, n_bad = 0, wr_cnt = 0, both_cnt = 0;

    hamming_enc_engine dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .o_busy(busy), .o_done(done),
        .o_mem_addr(addr), .o_mem_rd_en(rd_en), .i_mem_rd_data(rd_data),
        .o_mem_wr_en(wr_en), .o_mem_wr_data(wr_data), .o_fmt_err(fmt_err)
    );

    always #5 clk = ~clk;

    // byte memory: one-cycle read latency, write on the strobed edge
    always @(posedge clk) begin
        if (rd_en) rd_data <= src_mem[addr];
        if (wr_en) begin
            dst_mem[addr] <= wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (rd_en && wr_en) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // classic Hamming layout: data in non-power-of-two positions, parity bits zero the syndrome
    function automatic logic [15:0] enc(input logic [10:0] m);
        logic [15:0] c = '0;
        logic [3:0]  syn = '0;
        int k = 0;
        for (int pos = 1; pos < 16; pos++)
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = m[k];
                k++;
            end
        for (int pos = 1; pos < 16; pos++)
            if (c[pos]) syn ^= 4'(pos);
        for (int j = 0; j < 4; j++) c[1 << j] = syn[j];
        c[0] = ^c[15:1];
        return c;
    endfunction

    task automatic put(input int i, input logic [7:0] lo, input logic [7:0] hi);
        src_mem[2*i]   = lo;
        src_mem[2*i+1] = hi;
        msg[i]         = {hi[2:0], lo};
    endtask

    task automatic load_random();
        for (int i = 0; i < NUM_MSG; i++) begin
            logic [10:0] m;
            m = 11'($urandom);
            put(i, m[7:0], {5'b0, m[10:8]});
        end
    endtask

    task automatic check_run();
        logic [15:0] got;
        logic        efmt = 1'b0;
        for (int i = 0; i < NUM_MSG; i++) begin
            got = {dst_mem[DST+2*i+1], dst_mem[DST+2*i]};
            chk($sformatf("cw%0d", i), 32'(got), 32'(enc(msg[i])));
            chk($sformatf("par%0d", i), 32'(^got), 32'd0);
`ifdef HAM_ENC_CHECK_EN
            efmt |= |src_mem[2*i+1][7:3];
`endif
        end
        chk("fmt_err", 32'(fmt_err), 32'(efmt));
    endtask

    task automatic run(input int pulse_at, input int rst_at);
        int cyc, w0;
        w0 = wr_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("busy_on", 32'(busy), 32'd1);
        chk("done_clr", 32'(done), 32'd0);
        cyc = 0;
        while (!done && cyc < 200) begin
            start = (cyc == pulse_at);
            if (cyc == rst_at) begin
                start = 1'b0;
                reset = 1'b0;
                @(negedge clk) reset = 1'b1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                w0 = wr_cnt;
                repeat (20) @(negedge clk);
                chk("rst_no_wr", 32'(wr_cnt - w0), 32'd0);
                chk("rst_idle", 32'(busy), 32'd0);
                return;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("latency", 32'(cyc), 32'd75);
        chk("busy_off", 32'(busy), 32'd0);
        chk("idle_rd", 32'(rd_en), 32'd0);
        chk("idle_wr", 32'(wr_en), 32'd0);
        chk("wr_count", 32'(wr_cnt - w0), 32'(2 * NUM_MSG));
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 256; i++) src_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("r_busy", 32'(busy), 32'd0);
        chk("r_done", 32'(done), 32'd0);
        chk("r_rd", 32'(rd_en), 32'd0);
        chk("r_wr", 32'(wr_en), 32'd0);
        chk("r_addr", 32'(addr), 32'd0);
        chk("r_wdata", 32'(wr_data), 32'd0);
        chk("r_fmt", 32'(fmt_err), 32'd0);
        reset = 1'b1;
        load_random();
        put(0, 8'h00, 8'h00);
        put(1, 8'h01, 8'h00);
        put(2, 8'hFF, 8'h07);
        put(3, 8'h00, 8'h04);
        run(-1, -1);
        check_run();
        chk("m30", 32'(dst_mem[30]), 32'h00);
        chk("m31", 32'(dst_mem[31]), 32'h00);
        chk("m32", 32'(dst_mem[32]), 32'h0F);
        chk("m34", 32'(dst_mem[34]), 32'hFF);
        chk("m35", 32'(dst_mem[35]), 32'hFF);
        chk("m36", 32'(dst_mem[36]), 32'h17);
        chk("m37", 32'(dst_mem[37]), 32'h81);
        load_random();
        put(0, 8'h01, 8'h00);
        run(30, -1);
        check_run();
        chk("m30b", 32'(dst_mem[30]), 32'h0F);
        chk("m31b", 32'(dst_mem[31]), 32'h00);
        load_random();
        run(-1, 20);
        run(-1, -1);
        check_run();
        load_random();
        put(5, 8'($urandom), 8'hF9);
        run(-1, -1);
        check_run();
        for (int r = 0; r < 3; r++) begin
            load_random();
            run(-1, -1);
            check_run();
        end
        chk("rdwr_excl", 32'(both_cnt), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
